// File: rtl/data_ram_if.sv
// data_ram_if: access bus of the data RAM (enable, read/write, address, write data, read data)
//   master: drives enab, rw, addr, data_in; receives data_out
//   slave : receives enab, rw, addr, data_in; drives data_out
interface data_ram_if #(
   parameter int d_width = 8,
   parameter int a_width = 8
) ();
   logic               enab;
   logic               rw;
   logic [a_width-1:0] addr;
   logic [d_width-1:0] data_in;
   logic [d_width-1:0] data_out;
   modport master (output enab, rw, addr, data_in, input data_out);
   modport slave  (input enab, rw, addr, data_in, output data_out);
endinterface

// File: rtl/data_ram.sv
// data_ram: 16-word single-port synchronous RAM with registered read and per-word monitor outputs
//   i_clk          rising-edge clock
//   i_clr          asynchronous active-low clear of all words and read data
//   bus            enab/rw/addr/data_in in, registered data_out out
//   o_mem0..15     combinational view of every stored word
module data_ram #(
   parameter int d_width = 8,
   parameter int a_width = 8,
   parameter int depth   = 16
) (
   input  logic               i_clk,
   input  logic               i_clr,
   data_ram_if.slave          bus,
   output logic [d_width-1:0] o_mem0,
   output logic [d_width-1:0] o_mem1,
   output logic [d_width-1:0] o_mem2,
   output logic [d_width-1:0] o_mem3,
   output logic [d_width-1:0] o_mem4,
   output logic [d_width-1:0] o_mem5,
   output logic [d_width-1:0] o_mem6,
   output logic [d_width-1:0] o_mem7,
   output logic [d_width-1:0] o_mem8,
   output logic [d_width-1:0] o_mem9,
   output logic [d_width-1:0] o_mem10,
   output logic [d_width-1:0] o_mem11,
   output logic [d_width-1:0] o_mem12,
   output logic [d_width-1:0] o_mem13,
   output logic [d_width-1:0] o_mem14,
   output logic [d_width-1:0] o_mem15
);
   logic [d_width-1:0] r_mem [depth];
   logic [d_width-1:0] r_data_out;
   logic [3:0]         w_idx;
   // upper address bits are ignored, so addresses wrap modulo 16
   assign w_idx = bus.addr[3:0];
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) begin
         for (int i = 0; i < depth; i++) r_mem[i] <= '0;
         r_data_out <= '0;
      end else if (bus.enab) begin
         if (bus.rw) r_mem[w_idx] <= bus.data_in;
         else r_data_out <= r_mem[w_idx];
      end
   end
   assign bus.data_out = r_data_out;
   assign o_mem0  = r_mem[0];
   assign o_mem1  = r_mem[1];
   assign o_mem2  = r_mem[2];
   assign o_mem3  = r_mem[3];
   assign o_mem4  = r_mem[4];
   assign o_mem5  = r_mem[5];
   assign o_mem6  = r_mem[6];
   assign o_mem7  = r_mem[7];
   assign o_mem8  = r_mem[8];
   assign o_mem9  = r_mem[9];
   assign o_mem10 = r_mem[10];
   assign o_mem11 = r_mem[11];
   assign o_mem12 = r_mem[12];
   assign o_mem13 = r_mem[13];
   assign o_mem14 = r_mem[14];
   assign o_mem15 = r_mem[15];
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized and directed checks of data_ram against an array model
module tb_data_ram;
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   started = 1'b0;
   logic [7:0] dm [16];
   logic [7:0] m  [16];
   logic [7:0] mo;
   data_ram_if #(.d_width(8), .a_width(8)) bus ();
   data_ram #(.d_width(8), .a_width(8), .depth(16)) dut (
      .i_clk(clk), .i_clr(clr), .bus(bus.slave),
      .o_mem0(dm[0]),   .o_mem1(dm[1]),   .o_mem2(dm[2]),   .o_mem3(dm[3]),
      .o_mem4(dm[4]),   .o_mem5(dm[5]),   .o_mem6(dm[6]),   .o_mem7(dm[7]),
      .o_mem8(dm[8]),   .o_mem9(dm[9]),   .o_mem10(dm[10]), .o_mem11(dm[11]),
      .o_mem12(dm[12]), .o_mem13(dm[13]), .o_mem14(dm[14]), .o_mem15(dm[15])
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask
   // reference: a plain 16-entry array, cleared whenever clr is low
   initial begin
      foreach (m[i]) m[i] = 8'h00;
      mo = 8'h00;
   end
   always @(negedge clr) begin
      foreach (m[i]) m[i] = 8'h00;
      mo = 8'h00;
   end
   always @(posedge clk) begin
      if (!clr) begin
         foreach (m[i]) m[i] = 8'h00;
         mo = 8'h00;
      end else if (bus.enab) begin
         if (bus.rw) m[bus.addr % 16] = bus.data_in;
         else mo = m[bus.addr % 16];
      end
   end
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), dm[i], m[i]);
         chk("data_out", bus.data_out, mo);
      end
   end
   task automatic drive(input logic e, input logic r, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      #1;
      bus.enab = e;
      bus.rw = r;
      bus.addr = a;
      bus.data_in = d;
   endtask
   initial begin
      bus.enab = 1'b0;
      bus.rw = 1'b0;
      bus.addr = 8'h00;
      bus.data_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_data_out", bus.data_out, 8'h00);
      chk("reset_mem0", dm[0], 8'h00);
      clr = 1'b1;
      started = 1'b1;
      // preload then clear between edges
      drive(1, 1, 8'h02, 8'h5A);
      drive(1, 1, 8'h07, 8'h5A);
      drive(1, 0, 8'h07, 8'h00);
      drive(0, 0, 8'h00, 8'h00);
      chk("preload_mem7", dm[7], 8'h5A);
      chk("preload_rd", bus.data_out, 8'h5A);
      clr = 1'b0;
      #2;
      chk("clr_mem2", dm[2], 8'h00);
      chk("clr_mem7", dm[7], 8'h00);
      chk("clr_data_out", bus.data_out, 8'h00);
      clr = 1'b1;
      // write then read same address
      drive(1, 1, 8'h03, 8'hA5);
      drive(1, 0, 8'h03, 8'h00);
      chk("wr_mem3", dm[3], 8'hA5);
      chk("wr_no_writethrough", bus.data_out, 8'h00);
      drive(0, 0, 8'h00, 8'h00);
      chk("rd_mem3", bus.data_out, 8'hA5);
      // disabled access
      repeat (3) drive(0, 1, 8'h05, 8'h3C);
      drive(0, 0, 8'h00, 8'h00);
      chk("dis_mem5", dm[5], 8'h00);
      chk("dis_hold", bus.data_out, 8'hA5);
      // address wrap
      drive(1, 1, 8'h13, 8'h77);
      drive(1, 0, 8'h03, 8'h00);
      drive(0, 0, 8'h00, 8'h00);
      chk("wrap_rd", bus.data_out, 8'h77);
      chk("wrap_mem3", dm[3], 8'h77);
      // streaming
      for (int i = 0; i < 16; i++) drive(1, 1, 8'(i), 8'(8'h10 + i));
      for (int i = 15; i >= 0; i--) begin
         drive(1, 0, 8'(i), 8'h00);
         if (i == 14) chk("stream_first", bus.data_out, 8'h1F);
      end
      drive(0, 0, 8'h00, 8'h00);
      chk("stream_last", bus.data_out, 8'h10);
      // clear held across a write edge
      drive(1, 1, 8'h09, 8'hFF);
      clr = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b1;
      chk("clrmid_mem9", dm[9], 8'h00);
      drive(1, 1, 8'h09, 8'h42);
      drive(0, 0, 8'h00, 8'h00);
      chk("clrmid_rewrite", dm[9], 8'h42);
      // random traffic with occasional clear pulses
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom % 4) != 0, $urandom % 2, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 99) == 0) begin
            clr = 1'b0;
            #1;
            clr = 1'b1;
         end
      end
      drive(0, 0, 8'h00, 8'h00);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
